kudu_stats_ctrl: RTL and testbench

Command-side driver for the simulation statistics collector. It snoops core data-bus stores to a magic command address, queues the decoded commands and replays them as a correctly shaped `start_stop` toggle pulse and `print_req` level pulse. The stats collector enables counting on a toggle and prints on a rising edge. Sits in the simulation top next to the DUT, between the core data interface and the stats collector.

---
 rtl/kudu_stats_ctrl.sv | 134 +++++++++++++
 tb/tb_kudu_stats_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kudu_stats_ctrl.sv
// Snoops core stores to CMD_ADDR, queues START/STOP/PRINT commands and replays them to the stats
// collector as a one-cycle start_stop toggle pulse or a PRINT_HOLD-cycle print_req level pulse.
module kudu_stats_ctrl #(
  parameter logic [31:0] CMD_ADDR   = 32'h8000_0010,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PRINT_HOLD = 4,
  parameter int          PRINT_GAP  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_gnt_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        start_stop_o,
  output logic        print_req_o,
  output logic        cnt_en_o,
  output logic        busy_o,
  output logic        cmd_drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2((PRINT_HOLD > PRINT_GAP ? PRINT_HOLD : PRINT_GAP) + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(PRINT_HOLD - 1);
  localparam logic [HW-1:0] GAP_INIT  = HW'(PRINT_GAP - 1);
  localparam logic [1:0]    CMD_START = 2'd1;
  localparam logic [1:0]    CMD_STOP  = 2'd2;
  localparam logic [1:0]    CMD_PRINT = 2'd3;

  typedef enum logic [1:0] {IDLE, PULSE, PRINT_HI, PRINT_LO} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          cnt_en_q, busy_q, drop_q;
  logic          capture, push_req, push, pop;
  logic [1:0]    head;

  assign capture  = data_req_i & data_gnt_i & data_we_i & (data_addr_i == CMD_ADDR);
  assign push_req = capture & (data_wdata_i[1:0] != 2'd0);
  assign pop      = (state_q == IDLE) & (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push     = push_req & ((count_q < FULL_CNT) | pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      drop_q  <= push_req & ~push;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_wdata_i[1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      cnt_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_en_q <= cnt_en_q ^ (state_q == PULSE);
      busy_q   <= (state_d != IDLE) | (count_d != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        // Redundant START/STOP is popped without leaving IDLE so the toggle stays in sync.
        if (pop) begin
          case (head)
            CMD_START: if (!cnt_en_q) state_d = PULSE;
            CMD_STOP:  if (cnt_en_q)  state_d = PULSE;
            CMD_PRINT: begin
              state_d = PRINT_HI;
              hold_d  = HOLD_INIT;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      PULSE: state_d = IDLE;
      PRINT_HI: begin
        if (hold_q == '0) begin
          state_d = PRINT_LO;
          hold_d  = GAP_INIT;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      PRINT_LO: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_stop_o = (state_q == PULSE);
    print_req_o  = (state_q == PRINT_HI);
    cnt_en_o     = cnt_en_q;
    busy_o       = busy_q;
    cmd_drop_o   = drop_q;
  end

endmodule

// File: tb/tb_kudu_stats_ctrl.sv
// Scoreboard bench for kudu_stats_ctrl: commands push expected output events, the monitor pops
// and compares them as start_stop pulses and print_req rising edges appear.
module tb_kudu_stats_ctrl;

  localparam logic [31:0] CMD_ADDR   = 32'h8000_0010;
  localparam int          FIFO_DEPTH = 4;
  localparam int          PRINT_HOLD = 4;
  localparam int          PRINT_GAP  = 2;
  localparam int          K_PULSE    = 1;
  localparam int          K_PRINT    = 2;

  typedef struct {
    int   kind;
    int   exp_cyc;
    logic en_before;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i, data_gnt_i, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        start_stop_o, print_req_o, cnt_en_o, busy_o, cmd_drop_o;

  kudu_stats_ctrl #(
    .CMD_ADDR  (CMD_ADDR),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PRINT_HOLD(PRINT_HOLD),
    .PRINT_GAP (PRINT_GAP)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_req_i  (data_req_i),
    .data_gnt_i  (data_gnt_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_wdata_i(data_wdata_i),
    .start_stop_o(start_stop_o),
    .print_req_o (print_req_o),
    .cnt_en_o    (cnt_en_o),
    .busy_o      (busy_o),
    .cmd_drop_o  (cmd_drop_o)
  );

  always #5 clk_i = ~clk_i;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   n_rise = 0;
  int   n_drop = 0;
  int   rise_cyc = 0;
  int   last_fall = -1000;
  logic print_prev = 1'b0;
  logic model_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (start_stop_o) begin
        n_pulse++;
        chk("ss_print_excl", print_req_o, 1'b0);
        if (exp_q.size() == 0) chk("ss_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ss_kind", mon_e.kind, K_PULSE);
          chk("ss_en_before", cnt_en_o, mon_e.en_before);
          if (mon_e.exp_cyc >= 0) chk("ss_latency", cyc, mon_e.exp_cyc);
        end
      end
      if (print_req_o && !print_prev) begin
        n_rise++;
        rise_cyc = cyc;
        chk("print_gap_ok", (cyc - last_fall) >= PRINT_GAP, 1'b1);
        if (exp_q.size() == 0) chk("print_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("print_kind", mon_e.kind, K_PRINT);
          chk("print_en", cnt_en_o, mon_e.en_before);
          if (mon_e.exp_cyc >= 0) chk("print_latency", cyc, mon_e.exp_cyc);
        end
      end
      if (!print_req_o && print_prev) begin
        last_fall = cyc;
        chk("print_hold", cyc - rise_cyc, PRINT_HOLD);
      end
      // A dropped command is always the most recently offered one.
      if (cmd_drop_o) begin
        n_drop++;
        if (exp_q.size() > 0) exp_q.pop_back();
      end
    end
    print_prev = print_req_o;
  end

  task automatic bus(input logic req, input logic gnt, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    data_req_i   = req;
    data_gnt_i   = gnt;
    data_we_i    = we;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    data_req_i   = 1'b0;
    data_gnt_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_wdata_i = '0;
  endtask

  task automatic cmd(input logic [1:0] c, input bit timed);
    exp_t        e;
    logic [31:0] wd;
    e.exp_cyc   = timed ? cyc + 2 : -1;
    e.en_before = model_en;
    e.kind      = 0;
    case (c)
      2'd1: if (!model_en) begin e.kind = K_PULSE; model_en = 1'b1; end
      2'd2: if (model_en)  begin e.kind = K_PULSE; model_en = 1'b0; end
      2'd3: e.kind = K_PRINT;
      default: e.kind = 0;
    endcase
    if (e.kind != 0) exp_q.push_back(e);
    wd       = $urandom();
    wd[1:0]  = c;
    bus(1'b1, 1'b1, 1'b1, CMD_ADDR, wd);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(posedge clk_i);
    #1;
    while (busy_o && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 1, 0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int p0, r0, d0, n;
    rst_i = 1'b0;
    data_req_i = 1'b0; data_gnt_i = 1'b0; data_we_i = 1'b0;
    data_addr_i = '0; data_wdata_i = '0;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_ss", start_stop_o, 1'b0);
    chk("rst_print", print_req_o, 1'b0);
    chk("rst_en", cnt_en_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_drop", cmd_drop_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single START captured at cycle 10.
    do begin @(posedge clk_i); #1; end while (cyc < 10);
    cmd(2'd1, 1'b1);
    chk("t1_busy_c11", busy_o, 1'b1);
    chk("t1_ss_c11", start_stop_o, 1'b0);
    @(posedge clk_i); #1;
    chk("t1_ss_c12", start_stop_o, 1'b1);
    chk("t1_en_c12", cnt_en_o, 1'b0);
    @(posedge clk_i); #1;
    chk("t1_ss_c13", start_stop_o, 1'b0);
    chk("t1_en_c13", cnt_en_o, 1'b1);
    wait_idle("t1");
    cmd(2'd2, 1'b1);
    wait_idle("t1_stop");
    chk("t1_en_off", cnt_en_o, 1'b0);

    // START, START, STOP back to back.
    p0 = n_pulse;
    cmd(2'd1, 1'b0);
    cmd(2'd1, 1'b0);
    cmd(2'd2, 1'b0);
    wait_idle("t2");
    chk("t2_pulses", n_pulse - p0, 2);
    chk("t2_en", cnt_en_o, 1'b0);
    chk("t2_q_empty", exp_q.size(), 0);

    // PRINT, PRINT.
    r0 = n_rise;
    cmd(2'd3, 1'b1);
    cmd(2'd3, 1'b0);
    wait_idle("t3");
    chk("t3_edges", n_rise - r0, 2);
    chk("t3_q_empty", exp_q.size(), 0);

    // Six PRINTs overflow the queue.
    r0 = n_rise;
    d0 = n_drop;
    for (int i = 0; i < 6; i++) cmd(2'd3, 1'b0);
    wait_idle("t4");
    chk("t4_dropped", (n_drop - d0) >= 1, 1'b1);
    chk("t4_edges", n_rise - r0, 6 - (n_drop - d0));
    chk("t4_q_empty", exp_q.size(), 0);

    // Non-command bus traffic.
    p0 = n_pulse; r0 = n_rise; d0 = n_drop;
    bus(1'b1, 1'b1, 1'b1, CMD_ADDR + 32'd4, 32'd1);
    chk("t5_busy_addr4", busy_o, 1'b0);
    bus(1'b1, 1'b1, 1'b0, CMD_ADDR, 32'd3);
    chk("t5_busy_read", busy_o, 1'b0);
    bus(1'b1, 1'b1, 1'b1, CMD_ADDR, 32'd0);
    chk("t5_busy_nop", busy_o, 1'b0);
    bus(1'b1, 1'b1, 1'b1, CMD_ADDR, 32'hFFFF_FFFC);
    chk("t5_busy_nop_hi", busy_o, 1'b0);
    bus(1'b1, 1'b0, 1'b1, CMD_ADDR, 32'd1);
    chk("t5_busy_nognt", busy_o, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("t5_busy_end", busy_o, 1'b0);
    chk("t5_no_activity", (n_pulse - p0) + (n_rise - r0) + (n_drop - d0), 0);

    // Reset in the middle of a print.
    cmd(2'd1, 1'b0);
    wait_idle("t6a");
    chk("t6_en_before", cnt_en_o, 1'b1);
    cmd(2'd3, 1'b0);
    n = 0;
    while (!print_req_o && n < 10) begin @(posedge clk_i); #1; n++; end
    chk("t6_print_seen", print_req_o, 1'b1);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("t6_print_async", print_req_o, 1'b0);
    chk("t6_en_async", cnt_en_o, 1'b0);
    chk("t6_busy_async", busy_o, 1'b0);
    exp_q.delete();
    model_en = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    p0 = n_pulse;
    cmd(2'd1, 1'b1);
    wait_idle("t6b");
    chk("t6_pulses", n_pulse - p0, 1);
    chk("t6_en_after", cnt_en_o, 1'b1);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
